ili9341_region_arbiter: RTL and testbench

//  Shares one ILI9341 SPI byte path between NUM_REQ pixel sources; each source requests a rectangular window.

---
 rtl/ili9341_region_arbiter_if.sv | 32 +++
 rtl/ili9341_region_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ili9341_region_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ili9341_region_arbiter_if.sv
// ili9341_region_arbiter_if: request, pixel and byte-stream signals of the ILI9341 region arbiter
// slave modport: arbiter view; master modport: clients plus SPI transmitter view.
// Per-source vectors are packed, source i at [9i+:9] (bounds) and [16i+:16] (pixels).
interface ili9341_region_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic                    initDone;
  logic [NUM_REQ-1:0]      reqValid;
  logic [9*NUM_REQ-1:0]    reqX0;
  logic [9*NUM_REQ-1:0]    reqX1;
  logic [9*NUM_REQ-1:0]    reqY0;
  logic [9*NUM_REQ-1:0]    reqY1;
  logic [NUM_REQ-1:0]      reqGrant;
  logic [NUM_REQ-1:0]      reqErr;
  logic [NUM_REQ-1:0]      reqDone;
  logic [NUM_REQ-1:0]      pixValid;
  logic [16*NUM_REQ-1:0]   pixData;
  logic [NUM_REQ-1:0]      pixReady;
  logic                    byteValid;
  logic                    byteReady;
  logic [7:0]              byteData;
  logic                    byteIsData;
  logic                    busy;
  modport slave (
    input  initDone, reqValid, reqX0, reqX1, reqY0, reqY1, pixValid, pixData, byteReady,
    output reqGrant, reqErr, reqDone, pixReady, byteValid, byteData, byteIsData, busy
  );
  modport master (
    output initDone, reqValid, reqX0, reqX1, reqY0, reqY1, pixValid, pixData, byteReady,
    input  reqGrant, reqErr, reqDone, pixReady, byteValid, byteData, byteIsData, busy
  );
endinterface

// File: rtl/ili9341_region_arbiter.sv
// ili9341_region_arbiter: round-robin sharing of one ILI9341 SPI byte path between windowed pixel sources
// Ports: CLK_I clock; RST_I asynchronous active-low reset; bus = slave modport of ili9341_region_arbiter_if
//   (window requests with grant/err/done pulses, per-source pixel handshake, command/parameter/pixel
//   byte stream to the SPI transmitter, busy).
// Optional feature: define ILI9341_ARB_STALL_TIMEOUT_EN to abort a window whose source leaves
//   pixValid low for STALL_TIMEOUT consecutive cycles while a pixel is awaited.
module ili9341_region_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int COLS          = 240,
  parameter int ROWS          = 320,
  parameter int STALL_TIMEOUT = 1024
) (
  input logic CLK_I,
  input logic RST_I,
  ili9341_region_arbiter_if.slave bus
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ARB      = 4'd1;
  localparam logic [3:0] CASET_C  = 4'd2;
  localparam logic [3:0] CASET_P  = 4'd3;
  localparam logic [3:0] PASET_C  = 4'd4;
  localparam logic [3:0] PASET_P  = 4'd5;
  localparam logic [3:0] RAMWR_C  = 4'd6;
  localparam logic [3:0] PIX_LOAD = 4'd7;
  localparam logic [3:0] PIX_HI   = 4'd8;
  localparam logic [3:0] PIX_LO   = 4'd9;
  localparam logic [3:0] DONE     = 4'd10;

  if (NUM_REQ < 1 || NUM_REQ > 8 || STALL_TIMEOUT < 1) begin : gBadParam
    $error("ili9341_region_arbiter: NUM_REQ must be 1..8 and STALL_TIMEOUT positive");
  end

  logic [3:0]         state;
  logic [IW-1:0]      gSel, rrPtr, pickIdx;
  logic               found, legal, byteAcc, pv, stallHit;
  logic [8:0]         x0r, x1r, y0r, y1r, cx0, cx1, cy0, cy1, a0, a1;
  logic [16:0]        pixCount, w, h;
  logic [1:0]         pIdx;
  logic [15:0]        pixReg, pixIn;
  logic [7:0]         prm;
  logic [NUM_REQ-1:0] gOne, pOne;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (int'(i) + 1 >= NUM_REQ) ? '0 : i + 1'b1;
  endfunction

  // first pending request at or after the round-robin pointer, wrapping
  always_comb begin
    int j;
    found = 1'b0;
    pickIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rrPtr) + k;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      if (!found && bus.reqValid[IW'(j)]) begin
        found = 1'b1;
        pickIdx = IW'(j);
      end
    end
  end

  always_comb begin
    cx0 = bus.reqX0[9*pickIdx +: 9];
    cx1 = bus.reqX1[9*pickIdx +: 9];
    cy0 = bus.reqY0[9*pickIdx +: 9];
    cy1 = bus.reqY1[9*pickIdx +: 9];
    legal = found && cx0 <= cx1 && int'(cx1) < COLS && cy0 <= cy1 && int'(cy1) < ROWS;
    w = 17'(cx1) - 17'(cx0) + 17'd1;
    h = 17'(cy1) - 17'(cy0) + 17'd1;
    pv = bus.pixValid[gSel];
    pixIn = bus.pixData[16*gSel +: 16];
    byteAcc = bus.byteValid && bus.byteReady;
    gOne = NUM_REQ'(1) << gSel;
    pOne = NUM_REQ'(1) << pickIdx;
    a0 = state == CASET_P ? x0r : y0r;
    a1 = state == CASET_P ? x1r : y1r;
    // coordinates go out big-endian as 16-bit values; only bit 8 can be set in the high byte
    prm = pIdx == 2'd0 ? {7'd0, a0[8]} : pIdx == 2'd1 ? a0[7:0] :
          pIdx == 2'd2 ? {7'd0, a1[8]} : a1[7:0];
    bus.byteValid = state inside {CASET_C, CASET_P, PASET_C, PASET_P, RAMWR_C, PIX_HI, PIX_LO};
    bus.byteIsData = state inside {CASET_P, PASET_P, PIX_HI, PIX_LO};
    bus.byteData = state == CASET_C ? 8'h2A : state == PASET_C ? 8'h2B : state == RAMWR_C ? 8'h2C :
                   state inside {CASET_P, PASET_P} ? prm : state == PIX_HI ? pixReg[15:8] :
                   state == PIX_LO ? pixReg[7:0] : 8'h00;
    bus.reqGrant = state == ARB && legal ? pOne : '0;
    bus.reqErr = state == ARB && found && !legal ? pOne : stallHit ? gOne : '0;
    bus.reqDone = state == DONE ? gOne : '0;
    bus.pixReady = state == PIX_LOAD ? gOne : '0;
    bus.busy = (state == ARB && legal) ||
               state inside {CASET_C, CASET_P, PASET_C, PASET_P, RAMWR_C, PIX_LOAD, PIX_HI, PIX_LO};
  end

`ifdef ILI9341_ARB_STALL_TIMEOUT_EN
  logic [15:0] stallCnt;
  // only PIX_LOAD can stall, so an abort never lands inside a byte handshake
  assign stallHit = state == PIX_LOAD && !pv && stallCnt == 16'(STALL_TIMEOUT - 1);
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) stallCnt <= '0;
    else stallCnt <= (state == PIX_LOAD && !pv && !stallHit) ? stallCnt + 16'd1 : '0;
  end
`else
  assign stallHit = 1'b0;
`endif

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state <= IDLE;
      gSel <= '0;
      rrPtr <= '0;
      x0r <= '0;
      x1r <= '0;
      y0r <= '0;
      y1r <= '0;
      pixCount <= '0;
      pIdx <= '0;
      pixReg <= '0;
    end else begin
      case (state)
        IDLE: if (bus.initDone && |bus.reqValid) state <= ARB;
        ARB: begin
          gSel <= pickIdx;
          x0r <= cx0;
          x1r <= cx1;
          y0r <= cy0;
          y1r <= cy1;
          pixCount <= w * h;
          pIdx <= '0;
          if (found && !legal) rrPtr <= nxt(pickIdx);
          state <= legal ? CASET_C : IDLE;
        end
        CASET_C: if (byteAcc) state <= CASET_P;
        CASET_P: if (byteAcc) begin
          pIdx <= pIdx + 2'd1;
          if (pIdx == 2'd3) state <= PASET_C;
        end
        PASET_C: if (byteAcc) state <= PASET_P;
        PASET_P: if (byteAcc) begin
          pIdx <= pIdx + 2'd1;
          if (pIdx == 2'd3) state <= RAMWR_C;
        end
        RAMWR_C: if (byteAcc) state <= PIX_LOAD;
        PIX_LOAD: if (pv) begin
          pixReg <= pixIn;
          state <= PIX_HI;
        end else if (stallHit) begin
          rrPtr <= nxt(gSel);
          state <= IDLE;
        end
        PIX_HI: if (byteAcc) state <= PIX_LO;
        PIX_LO: if (byteAcc) begin
          pixCount <= pixCount - 17'd1;
          state <= pixCount == 17'd1 ? DONE : PIX_LOAD;
        end
        DONE: begin
          rrPtr <= nxt(gSel);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ili9341_region_arbiter.sv
// tb_ili9341_region_arbiter: table-driven and directed checks of ili9341_region_arbiter
module tb_ili9341_region_arbiter;
  logic CLK_I = 1'b0;
  logic RST_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  ili9341_region_arbiter_if #(.NUM_REQ(2)) bus ();
  ili9341_region_arbiter #(.NUM_REQ(2), .COLS(240), .ROWS(320), .STALL_TIMEOUT(8)) dut (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .bus(bus)
  );

  typedef struct {
    int r;
    int x0, x1, y0, y1;
    bit err;
    int npix;
  } vec_t;

  vec_t vecs[8];
  int passCnt = 0;
  int totalCnt = 0;
  int grants[2], errs[2], dones[2];
  int bvCycles, holdViol, prViol, pixIdx;
  bit granted, dropNext, heldV;
  logic [8:0] held;
  logic [8:0] q[$];
  logic [8:0] expQ[$];
  logic busyAfter;

  task automatic chk(input string name, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic buildExp(input int x0, input int x1, input int y0, input int y1, input int npix);
    logic [8:0] b[4];
    logic [15:0] px;
    expQ.delete();
    b = '{9'(x0), 9'(x1), 9'(y0), 9'(y1)};
    expQ.push_back(9'h02A);
    expQ.push_back({1'b1, 7'd0, b[0][8]});
    expQ.push_back({1'b1, b[0][7:0]});
    expQ.push_back({1'b1, 7'd0, b[1][8]});
    expQ.push_back({1'b1, b[1][7:0]});
    expQ.push_back(9'h02B);
    expQ.push_back({1'b1, 7'd0, b[2][8]});
    expQ.push_back({1'b1, b[2][7:0]});
    expQ.push_back({1'b1, 7'd0, b[3][8]});
    expQ.push_back({1'b1, b[3][7:0]});
    expQ.push_back(9'h02C);
    for (int k = 0; k < npix; k++) begin
      px = 16'hA500 + 16'(k);
      expQ.push_back({1'b1, px[15:8]});
      expQ.push_back({1'b1, px[7:0]});
    end
  endtask

  task automatic cycle(input int r, input bit rnd);
    @(posedge CLK_I);
    #1;
    if (dropNext) begin
      bus.reqValid[r] = 1'b0;
      dropNext = 1'b0;
    end
    bus.byteReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.pixValid = '0;
    bus.pixValid[r] = granted && (!rnd || $urandom_range(0, 3) != 0);
    bus.pixData[16*r +: 16] = 16'hA500 + 16'(pixIdx);
    #1;
    for (int i = 0; i < 2; i++) begin
      grants[i] += int'(bus.reqGrant[i]);
      errs[i] += int'(bus.reqErr[i]);
      dones[i] += int'(bus.reqDone[i]);
    end
    if (bus.reqGrant[r]) begin
      granted = 1'b1;
      dropNext = 1'b1;
    end
    if (bus.reqErr[r]) dropNext = 1'b1;
    if (bus.byteValid) begin
      bvCycles++;
      if (heldV && {bus.byteIsData, bus.byteData} != held) holdViol++;
      if (bus.byteReady) begin
        q.push_back({bus.byteIsData, bus.byteData});
        heldV = 1'b0;
      end else begin
        held = {bus.byteIsData, bus.byteData};
        heldV = 1'b1;
      end
    end else if (heldV) holdViol++;
    if ((bus.pixReady & ~(granted ? (2'b01 << r) : 2'b00)) != 2'b00) prViol++;
    if (bus.pixValid[r] && bus.pixReady[r]) pixIdx++;
    if (bus.reqDone[r] || bus.reqErr[r]) granted = 1'b0;
  endtask

  task automatic applyVec(input vec_t v, input bit rnd);
    q.delete();
    grants = '{0, 0};
    errs = '{0, 0};
    dones = '{0, 0};
    bvCycles = 0;
    holdViol = 0;
    prViol = 0;
    pixIdx = 0;
    granted = 1'b0;
    dropNext = 1'b0;
    heldV = 1'b0;
    @(posedge CLK_I);
    #1;
    bus.reqX0[9*v.r +: 9] = 9'(v.x0);
    bus.reqX1[9*v.r +: 9] = 9'(v.x1);
    bus.reqY0[9*v.r +: 9] = 9'(v.y0);
    bus.reqY1[9*v.r +: 9] = 9'(v.y1);
    bus.reqValid[v.r] = 1'b1;
    for (int c = 0; c < 3000 && dones[v.r] + errs[v.r] == 0; c++) cycle(v.r, rnd);
    repeat (3) cycle(v.r, rnd);
    bus.reqValid = '0;
    busyAfter = bus.busy;
    chk($sformatf("r%0d outcome", v.r), dones[v.r] + errs[v.r], 1);
    chk($sformatf("r%0d other pulses", v.r), grants[1-v.r] + errs[1-v.r] + dones[1-v.r], 0);
    chk($sformatf("r%0d busy after", v.r), int'(busyAfter), 0);
    if (v.err) begin
      chk($sformatf("r%0d err", v.r), errs[v.r], 1);
      chk($sformatf("r%0d err grants", v.r), grants[v.r], 0);
      chk($sformatf("r%0d err byteValid cycles", v.r), bvCycles, 0);
    end else begin
      int mism = 0;
      buildExp(v.x0, v.x1, v.y0, v.y1, v.npix);
      for (int k = 0; k < expQ.size(); k++) if (k >= q.size() || q[k] !== expQ[k]) mism++;
      chk($sformatf("r%0d grant", v.r), grants[v.r], 1);
      chk($sformatf("r%0d done", v.r), dones[v.r], 1);
      chk($sformatf("r%0d byte count", v.r), q.size(), 11 + 2 * v.npix);
      chk($sformatf("r%0d byte stream mismatches", v.r), mism, 0);
      chk($sformatf("r%0d hold violations", v.r), holdViol, 0);
      chk($sformatf("r%0d pixReady to wrong source", v.r), prViol, 0);
    end
  endtask

  task automatic doReset();
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    repeat (2) @(posedge CLK_I);
    #1;
    RST_I = 1'b1;
  endtask

  initial begin
    logic [8:0] hdr[11];
    int order[$];
    int lastDone, gap, lat, grantCyc, hit, rstDone, mism;
    vecs[0] = '{0, 10, 19, 0, 1, 1'b0, 20};
    vecs[1] = '{1, 5, 4, 0, 0, 1'b1, 0};
    vecs[2] = '{1, 0, 0, 0, 320, 1'b1, 0};
    vecs[3] = '{0, 0, 0, 0, 0, 1'b0, 1};
    vecs[4] = '{1, 239, 239, 319, 319, 1'b0, 1};
    vecs[5] = '{0, 240, 240, 0, 0, 1'b1, 0};
    vecs[6] = '{1, 0, 1, 318, 319, 1'b0, 4};
    vecs[7] = '{0, 3, 3, 5, 4, 1'b1, 0};
    hdr = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h113, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02C};
    bus.initDone = 1'b1;
    bus.reqValid = '0;
    bus.reqX0 = '0;
    bus.reqX1 = '0;
    bus.reqY0 = '0;
    bus.reqY1 = '0;
    bus.pixValid = '0;
    bus.pixData = '0;
    bus.byteReady = 1'b0;
    @(posedge CLK_I);
    #2;
    chk("reset byteValid", int'(bus.byteValid), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset pulses", int'({bus.reqGrant, bus.reqErr, bus.reqDone, bus.pixReady}), 0);
    chk("reset byteData", int'({bus.byteIsData, bus.byteData}), 0);
    #1;
    RST_I = 1'b1;

    foreach (vecs[i]) applyVec(vecs[i], 1'b0);

    applyVec(vecs[0], 1'b1);
    mism = 0;
    for (int k = 0; k < 11; k++) if (k >= q.size() || q[k] !== hdr[k]) mism++;
    chk("random-ready header vs constants", mism, 0);

    doReset();
    bus.reqX0 = '0;
    bus.reqX1 = '0;
    bus.reqY0 = '0;
    bus.reqY1 = '0;
    bus.reqValid = 2'b11;
    bus.pixValid = 2'b11;
    bus.byteReady = 1'b1;
    lastDone = -1;
    gap = -1;
    lat = -1;
    grantCyc = -1;
    for (int c = 0; c < 400 && order.size() < 4; c++) begin
      @(posedge CLK_I);
      #2;
      if (bus.reqDone != 2'b00) lastDone = c;
      if (bus.reqGrant != 2'b00) begin
        order.push_back(bus.reqGrant[1] ? 1 : 0);
        grantCyc = c;
        if (lastDone >= 0 && gap < 0) gap = c - lastDone;
      end
      if (bus.byteValid && grantCyc >= 0 && lat < 0) lat = c - grantCyc;
    end
    bus.reqValid = '0;
    bus.pixValid = '0;
    chk("rr grant count", order.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr grant %0d", k), order.size() > k ? order[k] : -1, k % 2);
    chk("done to next grant cycles", gap, 2);
    chk("grant to byteValid cycles", lat, 1);

    doReset();
    bus.reqX1 = 18'(1);
    bus.reqValid = 2'b01;
    bus.pixValid = 2'b01;
    bus.pixData = 32'h0000A501;
    bus.byteReady = 1'b1;
    hit = 0;
    for (int c = 0; c < 100 && hit == 0; c++) begin
      @(posedge CLK_I);
      #2;
      if (bus.byteValid && bus.byteIsData && bus.byteData == 8'hA5) begin
        hit = 1;
        bus.byteReady = 1'b0;
      end
    end
    bus.reqValid = '0;
    chk("reached PIX_HI", hit, 1);
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    #1;
    chk("mid-seq reset byteValid", int'(bus.byteValid), 0);
    chk("mid-seq reset busy", int'(bus.busy), 0);
    chk("mid-seq reset pixReady", int'(bus.pixReady), 0);
    rstDone = 0;
    repeat (3) begin
      @(posedge CLK_I);
      #1;
      rstDone += int'(bus.reqDone[0]) + int'(bus.reqErr[0]);
    end
    chk("mid-seq reset no done/err", rstDone, 0);
    RST_I = 1'b1;
    bus.pixValid = '0;
    bus.reqX1 = '0;
    applyVec('{0, 2, 3, 7, 7, 1'b0, 2}, 1'b0);

`ifdef ILI9341_ARB_STALL_TIMEOUT_EN
    begin
      int prc, e, d, drop;
      doReset();
      bus.reqX0 = '0;
      bus.reqX1 = '0;
      bus.reqY0 = '0;
      bus.reqY1 = '0;
      bus.reqValid = 2'b01;
      bus.pixValid = '0;
      bus.byteReady = 1'b1;
      prc = 0;
      e = 0;
      d = 0;
      drop = 0;
      for (int c = 0; c < 200 && e == 0; c++) begin
        @(posedge CLK_I);
        #1;
        if (drop != 0) bus.reqValid = '0;
        #1;
        if (bus.reqGrant[0]) drop = 1;
        prc += int'(bus.pixReady[0]);
        e += int'(bus.reqErr[0]);
        d += int'(bus.reqDone[0]);
      end
      bus.reqValid = '0;
      @(posedge CLK_I);
      #2;
      chk("stall pixReady cycles", prc, 8);
      chk("stall err", e, 1);
      chk("stall no done", d, 0);
      chk("stall busy after", int'(bus.busy), 0);
    end
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
